// File: rtl/icache_ctrl_if.sv
// Fetch, refill-memory and data-array signals of the instruction cache controller.
// The slave modport is the controller's view; the master modport is its environment's view.
interface icache_ctrl_if #(
  parameter int IDX_LEN = 7,
  parameter int BLK_LEN = 6
);
  logic               ifu_req_valid;
  logic [31:0]        ifu_addr;
  logic               ifu_req_ready;
  logic               ifu_rvalid;
  logic [31:0]        ifu_rdata;
  logic               fence_i;

  logic               mem_req_valid;
  logic [31:0]        mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rvalid;
  logic [31:0]        mem_rdata;
  logic               mem_rlast;

  logic [IDX_LEN-1:0] icache_index_o;
  logic [BLK_LEN-1:0] icache_blk_addr_o;
  logic [127:0]       icache_line_wdata_o;
  logic [127:0]       icache_wmask_o;
  logic [3:0]         burst_count_o;
  logic               icache_wen_o;
  logic [127:0]       icache_rdata_i;

  modport slave (
    input  ifu_req_valid, ifu_addr, fence_i,
           mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, icache_rdata_i,
    output ifu_req_ready, ifu_rvalid, ifu_rdata,
           mem_req_valid, mem_req_addr,
           icache_index_o, icache_blk_addr_o, icache_line_wdata_o,
           icache_wmask_o, burst_count_o, icache_wen_o
  );

  modport master (
    output ifu_req_valid, ifu_addr, fence_i,
           mem_req_ready, mem_rvalid, mem_rdata, mem_rlast, icache_rdata_i,
    input  ifu_req_ready, ifu_rvalid, ifu_rdata,
           mem_req_valid, mem_req_addr,
           icache_index_o, icache_blk_addr_o, icache_line_wdata_o,
           icache_wmask_o, burst_count_o, icache_wen_o
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: tag/valid flops, lookup, line refill over
// a 16-beat burst into an external 128-bit-wide data array, and fence.i invalidation.
module icache_ctrl #(
  parameter int IDX_LEN = 7,
  parameter int BLK_LEN = 6,
  parameter int TAG_LEN = 19
) (
  input  logic         clk,
  input  logic         rst,
  icache_ctrl_if.slave bus
);
  localparam int NUM_SETS = 1 << IDX_LEN;
  localparam int TAG_LO   = 32 - TAG_LEN;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, REREAD} state_t;

  state_t               state, state_next;
  logic [31:0]          req_addr;
  logic [3:0]           burst_cnt;
  logic [NUM_SETS-1:0]  valid;
  logic [TAG_LEN-1:0]   tags [NUM_SETS];

  logic [IDX_LEN-1:0]   req_idx;
  logic [TAG_LEN-1:0]   req_tag;
  logic                 hit, accept, beat, line_done;

  assign req_idx   = req_addr[BLK_LEN +: IDX_LEN];
  assign req_tag   = req_addr[31:TAG_LO];
  assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);
  assign accept    = (state == IDLE) && !bus.fence_i && bus.ifu_req_valid;
  assign beat      = (state == REFILL) && bus.mem_rvalid;
  // A last-beat flag closes the line whatever the beat count has reached.
  assign line_done = beat && bus.mem_rlast;

  assign bus.mem_req_addr        = {req_addr[31:BLK_LEN], {BLK_LEN{1'b0}}};
  assign bus.icache_line_wdata_o = {4{bus.mem_rdata}};
  assign bus.icache_wmask_o      = 128'(32'hFFFF_FFFF) << {burst_cnt[1:0], 5'b0};
  assign bus.burst_count_o       = burst_cnt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next            = state;
    bus.ifu_req_ready     = 1'b0;
    bus.ifu_rvalid        = 1'b0;
    bus.ifu_rdata         = '0;
    bus.mem_req_valid     = 1'b0;
    bus.icache_wen_o      = 1'b0;
    bus.icache_index_o    = req_idx;
    bus.icache_blk_addr_o = req_addr[BLK_LEN-1:0];

    unique case (state)
      IDLE: begin
        bus.ifu_req_ready     = !bus.fence_i;
        bus.icache_index_o    = bus.ifu_addr[BLK_LEN +: IDX_LEN];
        bus.icache_blk_addr_o = bus.ifu_addr[BLK_LEN-1:0];
        if (accept) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          bus.ifu_rvalid = 1'b1;
          bus.ifu_rdata  = bus.icache_rdata_i[{req_addr[3:2], 5'b0} +: 32];
          state_next     = IDLE;
        end else begin
          state_next = MISS_REQ;
        end
      end
      MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_next = REFILL;
      end
      REFILL: begin
        bus.icache_blk_addr_o = BLK_LEN'({burst_cnt[3:2], 4'b0000});
        bus.icache_wen_o      = bus.mem_rvalid;
        if (line_done) state_next = REREAD;
      end
      REREAD:  state_next = LOOKUP;
      default: state_next = IDLE;
    endcase

    if (rst) begin
      bus.ifu_req_ready = 1'b0;
      bus.ifu_rvalid    = 1'b0;
      bus.ifu_rdata     = '0;
      bus.mem_req_valid = 1'b0;
      bus.icache_wen_o  = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      burst_cnt <= '0;
      valid     <= '0;
    end else begin
      state <= state_next;
      if (accept) req_addr <= bus.ifu_addr;
      if ((state == IDLE) && bus.fence_i) valid <= '0;
      // The victim set stays invalid for the whole refill so an abandoned refill cannot hit.
      if ((state == MISS_REQ) && bus.mem_req_ready) begin
        burst_cnt      <= '0;
        valid[req_idx] <= 1'b0;
      end
      if (beat) burst_cnt <= burst_cnt + 4'd1;
      if (line_done) valid[req_idx] <= 1'b1;
    end
  end

  // NOTE: the tag array has no reset; an entry is trusted only once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && line_done) tags[req_idx] <= req_tag;
  end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The block SHALL have parameters: IDX_LEN, default 7, set index width; BLK_LEN, default 6, line offset width (64-byte line); TAG_LEN, default 19, tag width (32-IDX_LEN-BLK_LEN).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 Fetch side: ifu_req_valid  in  1  fetch request; ifu_addr  in  32  fetch address (word aligned); ifu_req_ready  out  1  request accepted; ifu_rvalid  out  1  instruction valid (one-cycle pulse); ifu_rdata  out  32  instruction; fence_i  in  1  invalidate all lines.
REQ-004 Memory side: mem_req_valid  out  1  refill request; mem_req_addr  out  32  line-aligned address; mem_req_ready  in  1  request accepted; mem_rvalid  in  1  beat valid; mem_rdata  in  32  beat data; mem_rlast  in  1  final beat.
REQ-005 Data-array side: icache_index_o  out  IDX_LEN  set index; icache_blk_addr_o  out  BLK_LEN  line offset; icache_line_wdata_o  out  128  write data; icache_wmask_o  out  128  write mask, 1 = write; burst_count_o  out  4  beat number; icache_wen_o  out  1  write enable, active high; icache_rdata_i  in  128  read data, valid one cycle after address.

Function
REQ-006 The block SHALL be direct-mapped, holding 2^IDX_LEN tag entries and valid bits in internal flops.
REQ-007 States SHALL be IDLE, LOOKUP, MISS_REQ, REFILL, REREAD.
REQ-008 ifu_req_ready SHALL be 1 only in IDLE with fence_i = 0.
REQ-009 IDLE: fence_i = 1 SHALL clear all valid bits in that cycle, stay in IDLE; fence_i has priority over ifu_req_valid; fence_i in other states is ignored.
REQ-010 IDLE: ifu_req_valid & ifu_req_ready SHALL latch ifu_addr, drive index/offset from ifu_addr combinationally, and go to LOOKUP.
REQ-011 In all non-IDLE states, icache_index_o/icache_blk_addr_o SHALL come from the latched address, except REFILL where blk_addr = {burst_count[3:2], 4'b0}.
REQ-012 LOOKUP hit (valid & tag match): ifu_rvalid = 1 and ifu_rdata = icache_rdata_i word selected by latched addr[3:2] in the same cycle, then IDLE; hit latency 1 cycle after acceptance, throughput 1 fetch per 2 cycles.
REQ-013 LOOKUP miss: go to MISS_REQ.
REQ-014 MISS_REQ: mem_req_valid = 1, mem_req_addr = {latched addr[31:6], 6'b0}, held stable until mem_req_ready; on handshake, burst counter := 0, go to REFILL.
REQ-015 REFILL: each mem_rvalid beat SHALL assert icache_wen_o, burst_count_o = counter, icache_line_wdata_o = mem_rdata replicated 4x, icache_wmask_o = 32 ones at bit position 32*counter[1:0]; counter increments modulo 16.
REQ-016 On the beat with mem_rlast = 1 (expected counter = 15), the tag entry SHALL be written, valid set, state to REREAD; mem_rlast at another count is still treated as end of line.
REQ-017 REREAD SHALL issue a read (icache_wen_o = 0) at the latched address and go to LOOKUP, which then hits; miss latency = memory latency + 16 beats + 2 cycles.
REQ-018 mem_rvalid outside REFILL SHALL be ignored.
REQ-019 icache_wen_o SHALL be 0 outside REFILL beats; mem_req_valid 0 outside MISS_REQ.
REQ-020 Tag/valid of the set being refilled SHALL not be valid until REQ-016 completes.

Reset
REQ-021 rst SHALL force state IDLE, all valid bits 0, burst counter 0, ifu_rvalid 0, mem_req_valid 0, icache_wen_o 0, ifu_rdata 0.
REQ-022 rst during REFILL or MISS_REQ SHALL abandon the refill; the affected set remains invalid.

Verification
REQ-023 Cold fetch 0x8000_0004 after reset -> mem_req_addr 0x8000_0000, 16 beats written burst_count 0..15, ifu_rvalid with beat 1 data.
REQ-024 Repeat fetch 0x8000_0008 -> no mem_req_valid, ifu_rvalid exactly 1 cycle after acceptance, data = beat 2.
REQ-025 Fetch 0x8000_2000 (same index 0, new tag) -> refill evicts, following fetch 0x8000_0000 misses again.
REQ-026 fence_i pulse in IDLE then fetch 0x8000_0008 -> miss and refill; fence_i during REFILL -> ignored, line valid after.
REQ-027 mem_req_ready held low 10 cycles -> mem_req_valid/addr stable throughout; stray mem_rvalid in IDLE -> no write.
REQ-028 rst at beat 7 of refill -> IDLE, all outputs reset values, next fetch to same line misses.
